// File: rtl/nx1_dpram_rdstream.sv
// Sequential port-B reader for the 1k x 16 dual-port RAM: issues reads, buffers them in a FIFO, streams valid/ready.
// Optional NX1_RDSTREAM_LAST_EN adds OLAST, marking the final word of each command.
module nx1_dpram_rdstream #(
    parameter int AW         = 10,
    parameter int DW         = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    input  logic [AW-1:0] SADR,
    input  logic [AW:0]   LEN,
    input  logic          ABORT,
    output logic          BUSY,
    output logic          DONE,
    output logic [AW-1:0] RA,
    output logic          RCS,
    output logic          RWE,
    input  logic [DW-1:0] RI,
    output logic [DW-1:0] OD,
    output logic          OVALID,
`ifdef NX1_RDSTREAM_LAST_EN
    output logic          OLAST,
`endif
    input  logic          OREADY
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [AW:0] MAX_LEN = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   ra_q, ra_d;
    logic [AW:0]     issue_cnt_q, issue_cnt_d;
    logic [AW:0]     accept_cnt_q, accept_cnt_d;
    logic            inflight_q, inflight_d;
    logic            done_q, done_d;
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   mem_q [FIFO_DEPTH];
    logic [DW-1:0]   mem_d [FIFO_DEPTH];
    logic [DW-1:0]   last_od_q, last_od_d;
`ifdef NX1_RDSTREAM_LAST_EN
    logic [FIFO_DEPTH-1:0] flag_q, flag_d;
    logic                  inflight_last_q, inflight_last_d;
`endif

    logic [AW:0] len_clamped;
    logic        issue;
    logic        push;
    logic        pop;

    assign len_clamped = (LEN > MAX_LEN) ? MAX_LEN : LEN;
    // Occupancy uses registered count: a pop frees room for an issue only in the following cycle.
    assign issue  = (state_q == RUN) && (issue_cnt_q != '0)
                    && ((cnt_q + CW'(inflight_q)) < CW'(FIFO_DEPTH));
    assign push   = inflight_q;
    assign pop    = OVALID && OREADY;

    assign BUSY   = (state_q != IDLE);
    assign DONE   = done_q;
    assign RA     = ra_q;
    assign RCS    = issue;
    assign RWE    = 1'b0;
    assign OVALID = (cnt_q != '0);
    assign OD     = OVALID ? mem_q[rptr_q] : last_od_q;
`ifdef NX1_RDSTREAM_LAST_EN
    assign OLAST  = OVALID && flag_q[rptr_q];
`endif

    always_comb begin
        state_d      = state_q;
        ra_d         = ra_q;
        issue_cnt_d  = issue_cnt_q;
        accept_cnt_d = accept_cnt_q;
        inflight_d   = issue;
        done_d       = 1'b0;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        mem_d        = mem_q;
        last_od_d    = last_od_q;
        cnt_d        = cnt_q + CW'(push) - CW'(pop);
`ifdef NX1_RDSTREAM_LAST_EN
        flag_d          = flag_q;
        inflight_last_d = issue && (issue_cnt_q == (AW+1)'(1));
`endif

        if (push) begin
            mem_d[wptr_q] = RI;
            wptr_d        = wptr_q + PW'(1);
`ifdef NX1_RDSTREAM_LAST_EN
            flag_d[wptr_q] = inflight_last_q;
`endif
        end
        if (pop) begin
            rptr_d    = rptr_q + PW'(1);
            last_od_d = mem_q[rptr_q];
            if (accept_cnt_q != '0) begin
                accept_cnt_d = accept_cnt_q - (AW+1)'(1);
            end
        end
        if (issue) begin
            ra_d        = ra_q + AW'(1);
            issue_cnt_d = issue_cnt_q - (AW+1)'(1);
        end

        case (state_q)
            IDLE: begin
                if (START) begin
                    if (len_clamped != '0) begin
                        ra_d         = SADR;
                        issue_cnt_d  = len_clamped;
                        accept_cnt_d = len_clamped;
                        state_d      = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (issue_cnt_d == '0) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (accept_cnt_d == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (ABORT) begin
            state_d      = IDLE;
            issue_cnt_d  = '0;
            accept_cnt_d = '0;
            inflight_d   = 1'b0;
            done_d       = 1'b0;
            wptr_d       = '0;
            rptr_d       = '0;
            cnt_d        = '0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            ra_q         <= '0;
            issue_cnt_q  <= '0;
            accept_cnt_q <= '0;
            inflight_q   <= 1'b0;
            done_q       <= 1'b0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            cnt_q        <= '0;
            mem_q        <= '{default: '0};
            last_od_q    <= '0;
`ifdef NX1_RDSTREAM_LAST_EN
            flag_q          <= '0;
            inflight_last_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            ra_q         <= ra_d;
            issue_cnt_q  <= issue_cnt_d;
            accept_cnt_q <= accept_cnt_d;
            inflight_q   <= inflight_d;
            done_q       <= done_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            cnt_q        <= cnt_d;
            mem_q        <= mem_d;
            last_od_q    <= last_od_d;
`ifdef NX1_RDSTREAM_LAST_EN
            flag_q          <= flag_d;
            inflight_last_q <= inflight_last_d;
`endif
        end
    end

endmodule

// File: tb/tb_nx1_dpram_rdstream.sv
// Self-checking bench for nx1_dpram_rdstream: a registered-read RAM model plus a stream monitor,
// with expected word sequences computed directly as ram[(SADR+i) mod 1024].
module tb_nx1_dpram_rdstream;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic [9:0]  SADR;
    logic [10:0] LEN;
    logic        ABORT;
    logic        BUSY;
    logic        DONE;
    logic [9:0]  RA;
    logic        RCS;
    logic        RWE;
    logic [15:0] RI;
    logic [15:0] OD;
    logic        OVALID;
    logic        OREADY;
`ifdef NX1_RDSTREAM_LAST_EN
    logic        OLAST;
`endif

    nx1_dpram_rdstream #(.AW(10), .DW(16), .FIFO_DEPTH(4)) dut (
        .CLK(CLK), .RST(RST), .START(START), .SADR(SADR), .LEN(LEN), .ABORT(ABORT),
        .BUSY(BUSY), .DONE(DONE), .RA(RA), .RCS(RCS), .RWE(RWE), .RI(RI),
        .OD(OD), .OVALID(OVALID),
`ifdef NX1_RDSTREAM_LAST_EN
        .OLAST(OLAST),
`endif
        .OREADY(OREADY)
    );

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          rdy_rand = 1'b0;
    logic [15:0] ram [1024];

    logic [15:0] got_d [$];
    int          got_c [$];
    bit          got_l [$];
    logic [9:0]  ra_list [$];
    int          done_c [$];

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Registered-output RAM, port B
    always @(posedge CLK) if (RCS) RI <= ram[RA];

    always @(posedge CLK) begin
        #1;
        if (rdy_rand) OREADY = 1'($urandom_range(0, 1));
    end

    always @(negedge CLK) begin
        if (!RST) begin
            if (OVALID && OREADY) begin
                got_d.push_back(OD);
                got_c.push_back(cyc);
`ifdef NX1_RDSTREAM_LAST_EN
                got_l.push_back(OLAST);
`else
                got_l.push_back(1'b0);
`endif
            end
            if (RCS) ra_list.push_back(RA);
            if (DONE) done_c.push_back(cyc);
            if (RWE !== 1'b0) begin
                $display("FAIL rwe_tied_low: got %b required 0", RWE);
                failures++;
            end
        end
    end

    task automatic fill_ram(input bit ramp);
        for (int a = 0; a < 1024; a++) ram[a] = ramp ? 16'(16'h1000 + a) : 16'($urandom);
    endtask

    task automatic clear_q();
        got_d.delete(); got_c.delete(); got_l.delete(); ra_list.delete(); done_c.delete();
    endtask

    task automatic send_cmd(input logic [9:0] a, input logic [10:0] l, output int c0);
        @(posedge CLK); #1;
        SADR = a; LEN = l; START = 1'b1; c0 = cyc;
        @(posedge CLK); #1;
        START = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (done_c.size() > 0) begin ok = 1'b1; break; end
        end
        repeat (3) @(negedge CLK);
    endtask

    // Index of the first received word differing from the expected run (or missing), -1 if none.
    function automatic int first_diff(input logic [9:0] a, input int n);
        for (int i = 0; i < n; i++) begin
            if (i >= got_d.size()) return i;
            if (got_d[i] !== ram[(int'(a) + i) % 1024]) return i;
        end
        return -1;
    endfunction

    task automatic test_reset();
        RST = 1'b1; START = 1'b0; ABORT = 1'b0; OREADY = 1'b0; SADR = '0; LEN = '0;
        #12;
        checks++;
        if ({BUSY, DONE, RCS, RA, OVALID, OD} !== '0) begin
            $display("FAIL reset_outputs: got busy=%b done=%b rcs=%b ra=%h ovalid=%b od=%h required all 0",
                     BUSY, DONE, RCS, RA, OVALID, OD);
            failures++;
        end
        checks++;
        if (RWE !== 1'b0) begin $display("FAIL reset_rwe: got %b required 0", RWE); failures++; end
        @(negedge CLK); RST = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_basic();
        int c0; bit ok; int d; bit ra_ok;
        fill_ram(1'b1); clear_q(); OREADY = 1'b1;
        send_cmd(10'h010, 11'd4, c0);
        @(negedge CLK);
        checks++;
        if (BUSY !== 1'b1 || RCS !== 1'b1 || RA !== 10'h010) begin
            $display("FAIL basic_cycle1: got busy=%b rcs=%b ra=%h required 1 1 010", BUSY, RCS, RA);
            failures++;
        end
        wait_done(50, ok);
        checks++;
        if (!ok) begin $display("FAIL basic_done_timeout: no DONE within 50 cycles"); failures++; end
        d = first_diff(10'h010, 4);
        checks++;
        if (got_d.size() != 4 || d != -1) begin
            $display("FAIL basic_data: got %0d words, first diff %0d, required 4 words 1010..1013", got_d.size(), d);
            failures++;
        end
        checks++;
        if (got_c.size() == 4 && (got_c[0] - c0 != 3 || got_c[3] - c0 != 6)) begin
            $display("FAIL basic_latency: got first/last at %0d/%0d required 3/6", got_c[0] - c0, got_c[3] - c0);
            failures++;
        end
        checks++;
        if (done_c.size() != 1 || done_c[0] - c0 != 7) begin
            $display("FAIL basic_done_cycle: got %0d pulses first at %0d required 1 at 7",
                     done_c.size(), (done_c.size() > 0) ? done_c[0] - c0 : -1);
            failures++;
        end
        ra_ok = (ra_list.size() == 4);
        for (int i = 0; i < ra_list.size() && i < 4; i++) if (ra_list[i] !== 10'(16 + i)) ra_ok = 1'b0;
        checks++;
        if (!ra_ok) begin $display("FAIL basic_ra_seq: got %0d issues required 010..013", ra_list.size()); failures++; end
        checks++;
        if (OVALID !== 1'b0 || OD !== 16'h1013 || BUSY !== 1'b0) begin
            $display("FAIL basic_hold: got ovalid=%b od=%h busy=%b required 0 1013 0", OVALID, OD, BUSY);
            failures++;
        end
`ifdef NX1_RDSTREAM_LAST_EN
        checks++;
        if (got_l.size() != 4 || got_l[0] || got_l[1] || got_l[2] || !got_l[3]) begin
            $display("FAIL basic_olast: got flags %p required 0,0,0,1", got_l);
            failures++;
        end
`endif
    endtask

    task automatic test_backpressure();
        int c0; bit ok; int d; logic [9:0] a;
        fill_ram(1'b0); clear_q(); OREADY = 1'b0;
        a = 10'($urandom);
        send_cmd(a, 11'd8, c0);
        repeat (10) @(negedge CLK);
        checks++;
        if (ra_list.size() != 4 || got_d.size() != 0 || OVALID !== 1'b1) begin
            $display("FAIL bp_stall: got %0d issues %0d transfers ovalid=%b required 4 0 1",
                     ra_list.size(), got_d.size(), OVALID);
            failures++;
        end
        OREADY = 1'b1;
        wait_done(60, ok);
        d = first_diff(a, 8);
        checks++;
        if (!ok || got_d.size() != 8 || d != -1) begin
            $display("FAIL bp_stream: got done=%b %0d words first diff %0d required 8 in order", ok, got_d.size(), d);
            failures++;
        end
        checks++;
        if (ra_list.size() != 8 || done_c.size() != 1) begin
            $display("FAIL bp_counts: got %0d issues %0d dones required 8 1", ra_list.size(), done_c.size());
            failures++;
        end
    endtask

    task automatic test_wrap();
        int c0; bit ok; int d; bit ra_ok;
        logic [9:0] exp_ra [4];
        exp_ra = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        clear_q(); OREADY = 1'b1;
        send_cmd(10'h3FE, 11'd4, c0);
        wait_done(50, ok);
        ra_ok = (ra_list.size() == 4);
        for (int i = 0; i < ra_list.size() && i < 4; i++) if (ra_list[i] !== exp_ra[i]) ra_ok = 1'b0;
        checks++;
        if (!ra_ok) begin
            $display("FAIL wrap_ra: got %p required 3fe 3ff 000 001", ra_list);
            failures++;
        end
        d = first_diff(10'h3FE, 4);
        checks++;
        if (!ok || got_d.size() != 4 || d != -1) begin
            $display("FAIL wrap_data: got %0d words first diff %0d required 4", got_d.size(), d);
            failures++;
        end
    endtask

    task automatic test_edges();
        int c0; bit ok; int d; logic [9:0] a;
        clear_q(); OREADY = 1'b1;
        send_cmd(10'h055, 11'd0, c0);
        @(negedge CLK);
        checks++;
        if (DONE !== 1'b1 || BUSY !== 1'b0) begin
            $display("FAIL len0_done: got done=%b busy=%b required 1 0", DONE, BUSY);
            failures++;
        end
        repeat (4) @(negedge CLK);
        checks++;
        if (ra_list.size() != 0 || done_c.size() != 1) begin
            $display("FAIL len0_quiet: got %0d issues %0d dones required 0 1", ra_list.size(), done_c.size());
            failures++;
        end
        clear_q(); rdy_rand = 1'b1;
        a = 10'($urandom);
        send_cmd(a, 11'h7FF, c0);
        wait_done(6000, ok);
        rdy_rand = 1'b0; OREADY = 1'b1;
        d = first_diff(a, 1024);
        checks++;
        if (!ok || got_d.size() != 1024 || d != -1) begin
            $display("FAIL clamp_stream: got done=%b %0d words first diff %0d required 1024", ok, got_d.size(), d);
            failures++;
        end
        checks++;
        if (ra_list.size() != 1024 || done_c.size() != 1) begin
            $display("FAIL clamp_counts: got %0d issues %0d dones required 1024 1", ra_list.size(), done_c.size());
            failures++;
        end
    endtask

    task automatic test_abort();
        int c0; bit ok; int d; logic [9:0] a;
        fill_ram(1'b0); clear_q(); OREADY = 1'b1;
        a = 10'($urandom);
        send_cmd(a, 11'd16, c0);
        repeat (4) @(posedge CLK);
        #1 ABORT = 1'b1;
        @(posedge CLK); #1 ABORT = 1'b0;
        @(negedge CLK);
        checks++;
        if (OVALID !== 1'b0 || BUSY !== 1'b0) begin
            $display("FAIL abort_idle: got ovalid=%b busy=%b required 0 0", OVALID, BUSY);
            failures++;
        end
        repeat (6) @(negedge CLK);
        d = first_diff(a, 3);
        checks++;
        if (done_c.size() != 0 || got_d.size() != 3 || d != -1) begin
            $display("FAIL abort_stream: got %0d dones %0d words first diff %0d required 0 3 -1",
                     done_c.size(), got_d.size(), d);
            failures++;
        end
        clear_q();
        send_cmd(10'h100, 11'd1, c0);
        wait_done(30, ok);
        d = first_diff(10'h100, 1);
        checks++;
        if (!ok || got_d.size() != 1 || d != -1 || done_c.size() != 1) begin
            $display("FAIL abort_restart: got done=%b %0d words first diff %0d required 1 word mem[100]",
                     ok, got_d.size(), d);
            failures++;
        end
    endtask

    task automatic test_ignore();
        int c0; bit ok; int d; logic [9:0] a;
        clear_q(); OREADY = 1'b1;
        a = 10'($urandom_range(0, 10'h1F0));
        send_cmd(a, 11'd6, c0);
        @(posedge CLK); #1;
        SADR = 10'h200; LEN = 11'd3; START = 1'b1;
        @(posedge CLK); #1 START = 1'b0;
        wait_done(50, ok);
        repeat (4) @(negedge CLK);
        d = first_diff(a, 6);
        checks++;
        if (!ok || got_d.size() != 6 || d != -1) begin
            $display("FAIL ignore_stream: got %0d words first diff %0d required 6 from %h", got_d.size(), d, a);
            failures++;
        end
        checks++;
        if (ra_list.size() != 6 || ra_list[0] !== a || done_c.size() != 1) begin
            $display("FAIL ignore_counts: got %0d issues %0d dones required 6 1", ra_list.size(), done_c.size());
            failures++;
        end
    endtask

    task automatic test_back_to_back();
        int c0; bit ok; int d; logic [9:0] a; int n;
        fill_ram(1'b0); rdy_rand = 1'b1;
        for (int k = 0; k < 8; k++) begin
            clear_q();
            a = 10'($urandom);
            n = $urandom_range(1, 24);
            send_cmd(a, 11'(n), c0);
            wait_done(400, ok);
            d = first_diff(a, n);
            checks++;
            if (!ok || got_d.size() != n || d != -1 || ra_list.size() != n || done_c.size() != 1) begin
                $display("FAIL b2b_cmd%0d: got done=%b %0d words %0d issues first diff %0d required %0d",
                         k, ok, got_d.size(), ra_list.size(), d, n);
                failures++;
            end
`ifdef NX1_RDSTREAM_LAST_EN
            checks++;
            if (got_l.size() != n || !got_l[n-1] || got_l.sum() with (int'(item)) != 1) begin
                $display("FAIL b2b_olast%0d: got flags %p required only last set", k, got_l);
                failures++;
            end
`endif
        end
        rdy_rand = 1'b0; OREADY = 1'b1;
    endtask

    task automatic test_async_reset();
        int c0; bit ok; int d;
        clear_q(); OREADY = 1'b1;
        send_cmd(10'h2A0, 11'd12, c0);
        repeat (3) @(posedge CLK);
        #3 RST = 1'b1;
        #1;
        checks++;
        if ({BUSY, DONE, RCS, RA, OVALID, OD} !== '0) begin
            $display("FAIL async_reset: got busy=%b done=%b rcs=%b ra=%h ovalid=%b od=%h required all 0",
                     BUSY, DONE, RCS, RA, OVALID, OD);
            failures++;
        end
        @(negedge CLK); RST = 1'b0;
        repeat (2) @(negedge CLK);
        clear_q();
        send_cmd(10'h123, 11'd2, c0);
        wait_done(30, ok);
        d = first_diff(10'h123, 2);
        checks++;
        if (!ok || got_d.size() != 2 || d != -1) begin
            $display("FAIL post_reset_cmd: got %0d words first diff %0d required 2", got_d.size(), d);
            failures++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_edges();
        test_abort();
        test_ignore();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
